// File: rtl/mops_adc_scan_seq.sv
// mops_adc_scan_seq: walks every CAN bus and ADC channel, issues one
// CANopen SDO upload request per pair and checks the MOPS response.
//
// Ports:
//   clk_40, rst (sync, active-low)   clock and reset
//   start, node_id                   scan trigger and target node id
//   req_valid/req_ready/req_data     76-bit request handshake {can_id, payload}
//   resp_valid/resp_data             one-cycle response strobe and frame
//   bus_cnt, adc_ch                  bus/channel currently addressed
//   adc_value, value_valid           last good reading and its strobe
//   busy, done                       scan in progress / end-of-scan pulse
//   err_cnt, tmo_cnt                 saturating error and timeout counters
//
// Build option: define MOPS_SCAN_RETRY_EN to re-issue a request once
// after its first timeout before counting the timeout.

module mops_adc_scan_seq #(
    parameter int N_BUSES = 7,
    parameter int N_CH    = 35,
    parameter int TIMEOUT = 4000
) (
    input  logic        clk_40,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  node_id,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [75:0] req_data,
    input  logic        resp_valid,
    input  logic [75:0] resp_data,
    output logic [4:0]  bus_cnt,
    output logic [7:0]  adc_ch,
    output logic [15:0] adc_value,
    output logic        value_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt,
    output logic [15:0] tmo_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]    LAST_BUS = 5'(N_BUSES - 1);
    localparam logic [7:0]    LAST_CH  = 8'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        CHECK,
        NEXT,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     bus_q, bus_d;
    logic [7:0]     ch_q, ch_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    err_q, err_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [15:0]    val_q, val_d;
    logic           vv_q, vv_d;
    logic [6:0]     node_q, node_d;
    logic [75:0]    resp_q, resp_d;
`ifdef MOPS_SCAN_RETRY_EN
    logic           retry_q, retry_d;
`endif

    logic [11:0]    req_id;
    logic [11:0]    resp_id_exp;
    logic           resp_good;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // node id is captured at start so the request frame cannot change
    // underneath a pending handshake
    assign req_id      = {1'b0, 11'h600 + {4'b0, node_q}};
    assign resp_id_exp = {1'b0, 11'h580 + {4'b0, node_q}};

    // SDO upload response: byte0 = 0x43, bytes1..3 = index/subindex echo
    assign resp_good = (resp_q[75:64] == resp_id_exp) &&
                       (resp_q[63:56] == 8'h43) &&
                       (resp_q[55:32] == {8'h00, 8'h24, ch_q});

    // gated with rst so a pending request drops without waiting for an edge
    assign req_valid   = (state_q == SEND) && rst;
    assign req_data    = req_valid ?
                         {req_id, 8'h40, 8'h00, 8'h24, ch_q, 32'h0} : '0;
    assign bus_cnt     = bus_q;
    assign adc_ch      = ch_q;
    assign adc_value   = val_q;
    assign value_valid = vv_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err_cnt     = err_q;
    assign tmo_cnt     = tmo_q;

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        val_d   = val_q;
        vv_d    = 1'b0;
        node_d  = node_q;
        resp_d  = resp_q;
`ifdef MOPS_SCAN_RETRY_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bus_d   = '0;
                    ch_d    = '0;
                    err_d   = '0;
                    tmo_d   = '0;
                    node_d  = node_id;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (req_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // a response wins over a same-cycle expiry
                if (resp_valid) begin
                    resp_d  = resp_data;
                    state_d = CHECK;
                end else if (timer_q == TMO_LAST) begin
`ifdef MOPS_SCAN_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        tmo_d   = sat_inc(tmo_q);
                        state_d = NEXT;
                    end
`else
                    tmo_d   = sat_inc(tmo_q);
                    state_d = NEXT;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if (resp_good) begin
                    val_d = {resp_q[23:16], resp_q[31:24]};
                    vv_d  = 1'b1;
                end else begin
                    err_d = sat_inc(err_q);
                end
                state_d = NEXT;
            end
            NEXT: begin
`ifdef MOPS_SCAN_RETRY_EN
                retry_d = 1'b0;
`endif
                if (ch_q == LAST_CH) begin
                    ch_d = '0;
                    if (bus_q == LAST_BUS) begin
                        bus_d   = '0;
                        state_d = DONE;
                    end else begin
                        bus_d   = bus_q + 5'd1;
                        state_d = SEND;
                    end
                end else begin
                    ch_d    = ch_q + 8'd1;
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_40) begin
        if (!rst) begin
            state_q <= IDLE;
            bus_q   <= '0;
            ch_q    <= '0;
            timer_q <= '0;
            err_q   <= '0;
            tmo_q   <= '0;
            val_q   <= '0;
            vv_q    <= 1'b0;
            node_q  <= '0;
            resp_q  <= '0;
`ifdef MOPS_SCAN_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            val_q   <= val_d;
            vv_q    <= vv_d;
            node_q  <= node_d;
            resp_q  <= resp_d;
`ifdef MOPS_SCAN_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

endmodule

// File: doc/mops_adc_scan_seq.md
# mops_adc_scan_seq

Upstream stimulus stage for the MOPSHUB setup generator: on a start pulse it walks every CAN bus (0..N_BUSES-1) and, per bus, every ADC channel (0..N_CH-1). For each pair it emits one 76-bit CANopen SDO upload request to the generator's request input and waits for the matching MOPS response. It checks each response, publishes the ADC value and keeps error and timeout counters, replacing hand-driven `start_data_gen`/`adc_ch` stimulus with a self-checking scan.

## Interface
- N_BUSES, 7, number of buses scanned (1..32)
- N_CH, 35, ADC channels per bus (1..256)
- TIMEOUT, 4000, clk_40 cycles allowed from request acceptance to response
- clk_40  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; ignored unless idle
- node_id  in  7  CANopen node id of the MOPS under test
- req_valid  out  1  request on req_data valid
- req_ready  in  1  generator accepts request
- req_data  out  76  {can_id[11:0], payload[63:0]}
- resp_valid  in  1  one-cycle response strobe
- resp_data  in  76  {can_id[11:0], payload[63:0]}
- bus_cnt  out  5  bus currently addressed
- adc_ch  out  8  channel currently addressed
- adc_value  out  16  last good ADC reading
- value_valid  out  1  one-cycle strobe with adc_value
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- err_cnt  out  16  mismatching responses, saturating
- tmo_cnt  out  16  timeouts, saturating

## Operation
- States: IDLE, SEND, WAIT, CHECK, NEXT, DONE.
- IDLE: busy=0. On start=1, clear bus_cnt, adc_ch, err_cnt and tmo_cnt, then go to SEND.
- SEND: req_valid=1. req_data = {1'b0, 11'h600+node_id, 8'h40, 8'h00, 8'h24, adc_ch, 32'h0}; bus_cnt selects the target bus. req_data stays stable while req_valid=1. When req_valid&req_ready, go to WAIT and clear the timer.
- WAIT: the timer increments each cycle.
  - resp_valid=1: latch resp_data and go to CHECK.
  - Timer reaches TIMEOUT-1: increment tmo_cnt and go to NEXT.
  - Responses arriving outside WAIT are ignored.
- CHECK: a response is good when can_id == {1'b0, 11'h580+node_id}, payload byte0 == 8'h43, bytes1..3 == {00,24,adc_ch}.
  - Good: adc_value = {byte5, byte4} and value_valid pulses.
  - Bad: err_cnt increments.
  - Either way, go to NEXT.
- NEXT: if adc_ch == N_CH-1, set adc_ch to 0 and increment bus_cnt; otherwise increment adc_ch. If the last bus wrapped, go to DONE; otherwise go to SEND.
- DONE: done=1 for one cycle, then IDLE.
- Addition: 11'h600+node_id and 11'h580+node_id are computed modulo 2^11.
- Counters saturate at 16'hFFFF.
- start while busy is ignored.

## Timing
- Reset values: every output is 0, including adc_value and the counters; state is IDLE.
- start sampled high → req_valid=1 on the next cycle.
- Handshake completes in the cycle where req_valid&req_ready are both high.
- resp_valid in WAIT → value_valid (good response) or err_cnt update two cycles later (one cycle in CHECK, registered output).
- A response that arrives in the same cycle the timer expires is taken as a response, not a timeout.
- rst low mid-scan → back to reset values on the next edge with no done pulse; a pending req_valid drops immediately.
- Minimum per-channel period, with zero-latency ready and response: 4 cycles.

## Configuration
- MOPS_SCAN_RETRY_EN
  - Defined: the first timeout on a channel returns to SEND and re-issues the identical request without incrementing tmo_cnt. A second timeout on the same channel increments tmo_cnt and proceeds to NEXT. The retry flag clears in NEXT.
  - Undefined: every timeout counts immediately and advances, with no retry logic.

## Test plan
- N_BUSES=1, N_CH=2, node_id=2, ready tied 1, model answers 8'h43 with value 16'h0ABC → req can_id 12'h602 for both channels, two value_valid pulses with 16'h0ABC, done pulse, err_cnt=0.
- Response can_id 12'h583 with node_id=2 → err_cnt=1, no value_valid, scan continues to the next channel.
- No response, TIMEOUT=16 → tmo_cnt increments 16 cycles after acceptance. With MOPS_SCAN_RETRY_EN: two requests are issued per channel and tmo_cnt=1 per channel.
- req_ready held low for 10 cycles → req_data stable, req_valid high throughout, no timer advance.
- N_BUSES=3, N_CH=2 → bus_cnt sequence 0,0,1,1,2,2 with adc_ch 0,1,0,1,0,1; done after six transactions.
- rst low during WAIT on bus 1 → all outputs 0 next cycle, no done. A new start restarts at bus 0, ch 0.
